// File: rtl/conv_12_8_ctrl_if.sv
// Bundle between conv_12_8_ctrl, the 12->8 slide engine and the row consumer.
// master = controller side, slave = engine/consumer side.
interface conv_12_8_ctrl_if;
  // Engine bus: slide_start pulses once per band; slide_end marks slide_out valid.
  logic         slide_start;
  logic [239:0] slide_in;
  logic [24:0]  slide_filter;
  logic [71:0]  slide_out;
  logic         slide_end;

  // Row output: a row transfers on any rising edge where row_valid && row_ready;
  // row_data/row_idx/filt_idx are stable while row_valid is high and not yet taken.
  logic         row_valid;
  logic         row_ready;
  logic [71:0]  row_data;
  logic [2:0]   row_idx;
  logic [1:0]   filt_idx;

  modport master (
    output slide_start, slide_in, slide_filter,
    input  slide_out, slide_end,
    output row_valid, row_data, row_idx, filt_idx,
    input  row_ready
  );

  modport slave (
    input  slide_start, slide_in, slide_filter,
    output slide_out, slide_end,
    input  row_valid, row_data, row_idx, filt_idx,
    output row_ready
  );
endinterface

// File: rtl/conv_12_8_ctrl.sv
// Sequencer feeding 5-row bands of a latched 12x12 image to a 12->8 slide engine, filter-major.
// Optional engine timeout enabled by defining CONV_CTRL_TIMEOUT_EN.
module conv_12_8_ctrl #(
  parameter int N_FILT  = 2,
  parameter int TIMEOUT = 63
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [575:0]          img_in,
  input  logic [25*N_FILT-1:0]  filt_bank,
  conv_12_8_ctrl_if.master      bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_EMIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [1:0] LAST_FILT = 2'(N_FILT - 1);
  localparam logic [2:0] LAST_BAND = 3'd7;

  state_t               state;
  logic [575:0]         img_reg;
  logic [25*N_FILT-1:0] filt_reg;
  logic [2:0]           band;
  logic [1:0]           filt;

`ifdef CONV_CTRL_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [WAIT_W-1:0] wait_cnt;
`endif

  assign state_dbg = state;

  // Rows b..b+4 of an image; row 0 sits in the MSBs.
  function automatic logic [239:0] band_rows(input logic [575:0] img, input logic [2:0] b);
    return img[575 - 48*int'(b) -: 240];
  endfunction

  // Loop form keeps every select in range for any N_FILT.
  function automatic logic [24:0] filt_sel(input logic [25*N_FILT-1:0] bank, input logic [1:0] f);
    logic [24:0] r;
    r = '0;
    for (int k = 0; k < N_FILT; k++) begin
      if (int'(f) == k) r = bank[25*k +: 25];
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      img_reg          <= '0;
      filt_reg         <= '0;
      band             <= '0;
      filt             <= '0;
      bus.slide_start  <= 1'b0;
      bus.slide_in     <= '0;
      bus.slide_filter <= '0;
      bus.row_valid    <= 1'b0;
      bus.row_data     <= '0;
      bus.row_idx      <= '0;
      bus.filt_idx     <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
`ifdef CONV_CTRL_TIMEOUT_EN
      err              <= 1'b0;
      wait_cnt         <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            img_reg          <= img_in;
            filt_reg         <= filt_bank;
            band             <= '0;
            filt             <= '0;
            bus.slide_start  <= 1'b1;
            bus.slide_in     <= band_rows(img_in, 3'd0);
            bus.slide_filter <= filt_bank[24:0];
            busy             <= 1'b1;
`ifdef CONV_CTRL_TIMEOUT_EN
            err              <= 1'b0;
`endif
            state            <= S_LAUNCH;
          end
        end

        S_LAUNCH: begin
          bus.slide_start <= 1'b0;
`ifdef CONV_CTRL_TIMEOUT_EN
          wait_cnt        <= '0;
`endif
          state           <= S_WAIT;
        end

        S_WAIT: begin
          if (bus.slide_end) begin
            bus.row_data  <= bus.slide_out;
            bus.row_idx   <= band;
            bus.filt_idx  <= filt;
            bus.row_valid <= 1'b1;
            state         <= S_EMIT;
          end
`ifdef CONV_CTRL_TIMEOUT_EN
          else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            // Engine gave up on us: abandon the image without a done pulse.
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        S_EMIT: begin
          if (bus.row_ready) begin
            bus.row_valid <= 1'b0;
            if (band != LAST_BAND) begin
              band             <= band + 3'd1;
              bus.slide_start  <= 1'b1;
              bus.slide_in     <= band_rows(img_reg, band + 3'd1);
              bus.slide_filter <= filt_sel(filt_reg, filt);
              state            <= S_LAUNCH;
            end else if (filt != LAST_FILT) begin
              band             <= '0;
              filt             <= filt + 2'd1;
              bus.slide_start  <= 1'b1;
              bus.slide_in     <= band_rows(img_reg, 3'd0);
              bus.slide_filter <= filt_sel(filt_reg, filt + 2'd1);
              state            <= S_LAUNCH;
            end else begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          bus.slide_start <= 1'b0;
          bus.row_valid   <= 1'b0;
          busy            <= 1'b0;
          done            <= 1'b0;
          state           <= S_IDLE;
        end
      endcase
    end
  end

`ifndef CONV_CTRL_TIMEOUT_EN
  assign err = 1'b0;
`endif

endmodule
